// File: rtl/etapa_id_operandos.sv
// RV32I decode / operand-fetch stage with write-back bypass,
// immediate generation and a valid/ready ID/EX register.
module etapa_id_operandos #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rf_read_addr1,
  output logic [4:0]      rf_read_addr2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic            wb_enable,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic            illegal;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic            accept;

  assign opcode        = in_instr[6:0];
  assign rf_read_addr1 = in_instr[19:15];
  assign rf_read_addr2 = in_instr[24:20];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    imm     = '0;
    rd      = in_instr[11:7];
    illegal = 1'b0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC:
        imm = {{20{in_instr[31]}}, in_instr[31:20]};
      OP_STORE: begin
        imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        rd  = '0;
      end
      OP_BRANCH: begin
        imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
               in_instr[30:25], in_instr[11:8], 1'b0};
        rd  = '0;
      end
      OP_LUI, OP_AUIPC:
        imm = {in_instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
               in_instr[20], in_instr[30:21], 1'b0};
      OP_OP:
        imm = '0;
      default: begin
        illegal = 1'b1;
        rd      = '0;
      end
    endcase
  end

  // The regfile write lands only at the edge, so forward it here
  always_comb begin
    op1 = rf_read_data1;
    op2 = rf_read_data2;
    if (rf_read_addr1 == 5'd0)
      op1 = '0;
    else if (wb_enable && wb_addr == rf_read_addr1)
      op1 = wb_data;
    if (rf_read_addr2 == 5'd0)
      op2 = '0;
    else if (wb_enable && wb_addr == rf_read_addr2)
      op2 = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_val  <= '0;
      out_rs2_val  <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_val  <= op1;
      out_rs2_val  <= op2;
      out_imm      <= imm;
      out_rd       <= rd;
      out_opcode   <= opcode;
      out_funct3   <= in_instr[14:12];
      out_funct7b5 <= in_instr[30];
      out_illegal  <= illegal;
      rs1_q        <= rf_read_addr1;
      rs2_q        <= rf_read_addr2;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled: keep held operands coherent with later write-backs
      if (wb_enable && wb_addr != 5'd0 && wb_addr == rs1_q)
        out_rs1_val <= wb_data;
      if (wb_enable && wb_addr != 5'd0 && wb_addr == rs2_q)
        out_rs2_val <= wb_data;
    end
  end

endmodule

// File: tb/tb_etapa_id_operandos.sv
// Bench for etapa_id_operandos: directed scenarios plus random
// traffic against a regfile-shadow reference model.
module tb_etapa_id_operandos;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rf_read_addr1;
  logic [4:0]  rf_read_addr2;
  logic [31:0] rf_read_data1;
  logic [31:0] rf_read_data2;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_illegal;

  always #5 clk = ~clk;

  etapa_id_operandos dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .flush         (flush),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .wb_enable     (wb_enable),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rs1_val   (out_rs1_val),
    .out_rs2_val   (out_rs2_val),
    .out_imm       (out_imm),
    .out_rd        (out_rd),
    .out_opcode    (out_opcode),
    .out_funct3    (out_funct3),
    .out_funct7b5  (out_funct7b5),
    .out_illegal   (out_illegal)
  );

  // Shadow register file; x0 holds garbage so zeroing is exercised
  logic [31:0] regs [32];
  assign rf_read_data1 = regs[rf_read_addr1];
  assign rf_read_data2 = regs[rf_read_addr2];

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_imm;
  logic [4:0]  m_rd;
  logic [4:0]  m_a1;
  logic [4:0]  m_a2;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7;
  logic        m_ill;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] i,
                                     output logic [31:0] imm,
                                     output logic [4:0] rd,
                                     output logic ill);
    int s;
    int s20;
    int s25;
    int sgn;
    s   = int'(i);
    s20 = s >>> 20;
    s25 = s >>> 25;
    sgn = s >>> 31;
    imm = 32'd0;
    rd  = i[11:7];
    ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: imm = s20;
      7'h23: begin
        imm = (s25 << 5) | 32'(i[11:7]);
        rd  = 5'd0;
      end
      7'h63: begin
        imm = (sgn << 12) | (32'(i[7]) << 11)
            | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        rd  = 5'd0;
      end
      7'h37, 7'h17: imm = i & 32'hFFFF_F000;
      7'h6F:
        imm = (sgn << 20) | (32'(i[19:12]) << 12)
            | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      7'h33: imm = 32'd0;
      default: begin
        ill = 1'b1;
        rd  = 5'd0;
      end
    endcase
  endfunction

  function automatic logic [31:0] arch(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs[a];
  endfunction

  task automatic step();
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        ill;
    logic        acc;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    check("rf_addr1", 32'(rf_read_addr1), 32'(in_instr[19:15]));
    check("rf_addr2", 32'(rf_read_addr2), 32'(in_instr[24:20]));
    acc = in_valid && (!m_valid || out_ready) && !flush;
    if (rst) begin
      m_valid = 1'b0;
    end else if (acc) begin
      ref_decode(in_instr, imm, rd, ill);
      m_valid = 1'b1;
      m_pc    = in_pc;
      m_imm   = imm;
      m_rd    = rd;
      m_ill   = ill;
      m_op    = in_instr[6:0];
      m_f3    = in_instr[14:12];
      m_f7    = in_instr[30];
      m_a1    = in_instr[19:15];
      m_a2    = in_instr[24:20];
    end else if (flush || out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (wb_enable && wb_addr != 5'd0) regs[wb_addr] = wb_data;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_imm", out_imm, m_imm);
      check("out_rd", 32'(out_rd), 32'(m_rd));
      check("out_opcode", 32'(out_opcode), 32'(m_op));
      check("out_funct3", 32'(out_funct3), 32'(m_f3));
      check("out_funct7b5", 32'(out_funct7b5), 32'(m_f7));
      check("out_illegal", 32'(out_illegal), 32'(m_ill));
      // Held operands always track the architectural register value
      check("out_rs1_val", out_rs1_val, arch(m_a1));
      check("out_rs2_val", out_rs2_val, arch(m_a2));
    end
  endtask

  task automatic drive(input logic r, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    wb_enable = we;
    wb_addr   = wa;
    wb_data   = wd;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] i;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    i = $urandom;
    if ($urandom_range(0, 7) == 0)
      i[6:0] = 7'($urandom);
    else
      i[6:0] = ops[$urandom_range(0, 10)];
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  localparam logic [31:0] ADD_X7 = 32'h0070_00B3;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  initial begin
    m_valid = 1'b0;
    m_pc = '0; m_imm = '0; m_rd = '0; m_a1 = '0; m_a2 = '0;
    m_op = '0; m_f3 = '0; m_f7 = 1'b0; m_ill = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    regs[0] = 32'hDEAD_BEEF;
    rst = 1'b1; in_valid = 1'b1; in_instr = NOP; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    wb_enable = 1'b0; wb_addr = '0; wb_data = '0;

    drive(1, 1, 32'hFFF0_0293, 32'h40, 0, 0, 0, 0, 0);
    drive(1, 1, 32'hFFF0_0293, 32'h40, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_rs1", out_rs1_val, 32'd0);
    check("rst_rs2", out_rs2_val, 32'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_misc", {out_rd, out_opcode, out_funct3,
                       out_funct7b5, out_illegal}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    drive(0, 1, 32'hFFF0_0293, 32'h100, 0, 1, 0, 0, 0);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    check("addi_rd", 32'(out_rd), 32'd5);
    check("addi_rs1", out_rs1_val, 32'd0);
    check("addi_pc", out_pc, 32'h100);

    regs[3] = 32'h11;
    drive(0, 1, 32'h0031_80B3, 32'h104, 0, 1, 1, 5'd3, 32'h22);
    check("byp_rs1", out_rs1_val, 32'h22);
    check("byp_rs2", out_rs2_val, 32'h22);
    drive(0, 1, 32'h0000_00B3, 32'h108, 0, 1, 1, 5'd0, 32'h55);
    check("x0_rs1", out_rs1_val, 32'd0);
    check("x0_rs2", out_rs2_val, 32'd0);

    regs[7] = 32'hA;
    drive(0, 1, ADD_X7, 32'h200, 0, 1, 0, 0, 0);
    drive(0, 1, NOP, 32'h204, 0, 0, 0, 0, 0);
    drive(0, 1, NOP, 32'h204, 0, 0, 1, 5'd7, 32'hB);
    drive(0, 1, NOP, 32'h204, 0, 0, 0, 0, 0);
    check("stall_rs2", out_rs2_val, 32'hB);
    check("stall_pc", out_pc, 32'h200);
    drive(0, 1, NOP, 32'h204, 0, 1, 0, 0, 0);
    check("resume_pc", out_pc, 32'h204);

    drive(0, 1, NOP, 32'h300, 1, 0, 0, 0, 0);
    check("flush_valid", 32'(out_valid), 32'd0);
    drive(0, 1, NOP, 32'h304, 0, 1, 0, 0, 0);
    check("post_flush_pc", out_pc, 32'h304);

    drive(0, 1, 32'hFE00_0CE3, 32'h400, 0, 1, 0, 0, 0);
    check("beq_imm", out_imm, 32'hFFFF_FFF8);
    check("beq_rd", 32'(out_rd), 32'd0);
    drive(0, 1, 32'h1234_52B7, 32'h404, 0, 1, 0, 0, 0);
    check("lui_imm", out_imm, 32'h1234_5000);
    drive(0, 1, 32'h0000_007F, 32'h408, 0, 1, 0, 0, 0);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_imm", out_imm, 32'd0);
    check("ill_valid", 32'(out_valid), 32'd1);

    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0,
            rand_instr(),
            $urandom,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)),
            $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
